// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the byte-serial instruction fetch stage.
package fetch_unit_pkg;
    localparam int WORD_WIDTH = 32;
    localparam int INST_WIDTH = 32;
    localparam int DATA_WIDTH = 8;
    localparam int INST_BYTES = 4;
    localparam int CNT_W      = 3;

    // ADDI x0,x0,0
    localparam logic [INST_WIDTH-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH,
        ISSUE,
        FAULT
    } fetch_state_t;

    typedef logic [CNT_W-1:0] byte_cnt_t;

    localparam byte_cnt_t FULL_COUNT = byte_cnt_t'(INST_BYTES);
endpackage

// File: rtl/fetch_unit_inst_byte_buffer.sv
// Little-endian 4-byte instruction assembler: appends one byte per write,
// or takes a partially/fully assembled word from another buffer in one load.
module inst_byte_buffer
    import fetch_unit_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clear,
    input  logic                  i_we,
    input  logic [DATA_WIDTH-1:0] i_byte,
    input  logic                  i_load,
    input  logic [INST_WIDTH-1:0] i_load_word,
    input  byte_cnt_t             i_load_count,
    output byte_cnt_t             o_count,
    output logic                  o_full,
    output logic [INST_WIDTH-1:0] o_word
);
    logic [INST_WIDTH-1:0] word_q, word_d;
    byte_cnt_t             count_q, count_d;

    assign o_full  = (count_q == FULL_COUNT);
    assign o_count = count_q;
    assign o_word  = word_q;

    // Clear wins over load, load wins over a byte write.
    always_comb begin
        word_d  = word_q;
        count_d = count_q;
        if (i_clear) begin
            word_d  = '0;
            count_d = '0;
        end else if (i_load) begin
            word_d  = i_load_word;
            count_d = i_load_count;
        end else if (i_we && !o_full) begin
            for (int i = 0; i < INST_BYTES; i++) begin
                if (count_q == byte_cnt_t'(i)) begin
                    word_d[8*i +: 8] = i_byte;
                end
            end
            count_d = count_q + byte_cnt_t'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            word_q  <= '0;
            count_q <= '0;
        end else begin
            word_q  <= word_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads each instruction a byte per cycle, prefetches
// the next sequential one while the current executes, and handles redirects.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [WORD_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    output logic [WORD_WIDTH-1:0] o_imem_addr,
    input  logic [DATA_WIDTH-1:0] i_imem_data,
    output logic [INST_WIDTH-1:0] o_inst,
    output logic [WORD_WIDTH-1:0] o_pc,
    output logic                  o_inst_valid,
    input  logic                  i_exec_done,
    input  logic                  i_pc_change,
    input  logic [WORD_WIDTH-1:0] i_new_pc,
    output logic                  o_fault
);
    fetch_state_t          state_q, state_d;
    logic [WORD_WIDTH-1:0] pc_q, pc_d;
    logic [WORD_WIDTH-1:0] addr_q, addr_d;

    logic                  pri_we, pri_clear, pri_load, pri_full;
    byte_cnt_t             pri_count;
    logic [INST_WIDTH-1:0] pri_word;
    logic                  pf_we, pf_clear, pf_full;
    byte_cnt_t             pf_count;
    logic [INST_WIDTH-1:0] pf_word;

    logic [INST_WIDTH-1:0] merged_word;
    byte_cnt_t             merged_count;

    inst_byte_buffer u_primary (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_clear      (pri_clear),
        .i_we         (pri_we),
        .i_byte       (i_imem_data),
        .i_load       (pri_load),
        .i_load_word  (merged_word),
        .i_load_count (merged_count),
        .o_count      (pri_count),
        .o_full       (pri_full),
        .o_word       (pri_word)
    );

    inst_byte_buffer u_prefetch (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_clear      (pf_clear),
        .i_we         (pf_we),
        .i_byte       (i_imem_data),
        .i_load       (1'b0),
        .i_load_word  ('0),
        .i_load_count ('0),
        .o_count      (pf_count),
        .o_full       (pf_full),
        .o_word       (pf_word)
    );

    assign o_imem_addr  = addr_q;
    assign o_pc         = pc_q;
    assign o_inst_valid = (state_q == ISSUE) && pri_full;
    assign o_inst       = o_inst_valid ? pri_word : NOP_INST;
    assign o_fault      = (state_q == FAULT);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        pri_we    = 1'b0;
        pri_clear = 1'b0;
        pri_load  = 1'b0;
        pf_we     = 1'b0;
        pf_clear  = 1'b0;

        // Prefetch contents including the byte arriving this cycle, so a
        // sequential hand-off never has to re-read it.
        merged_word  = pf_word;
        merged_count = pf_count;
        if (!pf_full) begin
            merged_word[{pf_count[1:0], 3'b000} +: 8] = i_imem_data;
            merged_count = pf_count + byte_cnt_t'(1);
        end

        case (state_q)
            FETCH: begin
                pri_we = 1'b1;
                if (pri_count == FULL_COUNT - byte_cnt_t'(1)) begin
                    state_d = ISSUE;
                    addr_d  = pc_q + 32'd4;
                end else begin
                    addr_d = pc_q + 32'(pri_count) + 32'd1;
                end
            end
            ISSUE: begin
                pf_we = !pf_full;
                if (merged_count != FULL_COUNT) begin
                    addr_d = pc_q + 32'd4 + 32'(merged_count);
                end
                if (i_exec_done) begin
                    pf_we = 1'b0;
                    if (i_pc_change) begin
                        if (i_new_pc[1:0] != 2'b00) begin
                            state_d = FAULT;
                            addr_d  = addr_q;
                        end else begin
                            state_d   = FETCH;
                            pc_d      = i_new_pc;
                            addr_d    = i_new_pc;
                            pri_clear = 1'b1;
                            pf_clear  = 1'b1;
                        end
                    end else begin
                        pc_d     = pc_q + 32'd4;
                        pri_load = 1'b1;
                        pf_clear = 1'b1;
                        if (merged_count == FULL_COUNT) begin
                            state_d = ISSUE;
                            addr_d  = pc_q + 32'd8;
                        end else begin
                            state_d = FETCH;
                            addr_d  = pc_q + 32'd4 + 32'(merged_count);
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized done/redirect traffic
// checked against a byte-stream model of the fetch stage.
module tb_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  mem [0:1023];

    logic        rst_n     [2];
    logic        done      [2];
    logic        chg       [2];
    logic [31:0] npc       [2];
    logic [31:0] imem_addr [2];
    logic [7:0]  imem_data [2];
    logic [31:0] inst      [2];
    logic [31:0] pc        [2];
    logic        valid     [2];
    logic        fault     [2];

    assign imem_data[0] = mem[imem_addr[0][9:0]];
    assign imem_data[1] = mem[imem_addr[1][9:0]];

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n[0]), .o_imem_addr(imem_addr[0]),
        .i_imem_data(imem_data[0]), .o_inst(inst[0]), .o_pc(pc[0]),
        .o_inst_valid(valid[0]), .i_exec_done(done[0]), .i_pc_change(chg[0]),
        .i_new_pc(npc[0]), .o_fault(fault[0])
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n[1]), .o_imem_addr(imem_addr[1]),
        .i_imem_data(imem_data[1]), .o_inst(inst[1]), .o_pc(pc[1]),
        .o_inst_valid(valid[1]), .i_exec_done(done[1]), .i_pc_change(chg[1]),
        .i_new_pc(npc[1]), .o_fault(fault[1])
    );

    int checks = 0;
    int errors = 0;

    // Model: the unit reads a sequential byte stream starting at m_pc;
    // m_bytes counts bytes already read from m_pc onward (at most 8).
    logic [31:0] m_pc    [2];
    logic [31:0] m_addr  [2];
    int          m_bytes [2];
    bit          m_fault [2];

    function automatic logic [31:0] rst_pc_of(int u);
        return (u == 0) ? 32'h0000_0000 : 32'hFFFF_FFFC;
    endfunction

    function automatic logic [31:0] word_at(logic [31:0] a);
        logic [31:0] b;
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 4; i++) begin
            b = a + 32'(i);
            w[8*i +: 8] = mem[b[9:0]];
        end
        return w;
    endfunction

    function automatic logic [97:0] exp_vec(int u);
        bit v;
        v = !m_fault[u] && (m_bytes[u] >= 4);
        return {m_addr[u], m_pc[u], (v ? word_at(m_pc[u]) : NOP), v, m_fault[u]};
    endfunction

    function automatic logic [97:0] obs_vec(int u);
        return {imem_addr[u], pc[u], inst[u], valid[u], fault[u]};
    endfunction

    task automatic model_step(int u);
        bit v;
        if (!rst_n[u]) begin
            m_pc[u]    = rst_pc_of(u);
            m_addr[u]  = rst_pc_of(u);
            m_bytes[u] = 0;
            m_fault[u] = 1'b0;
            return;
        end
        if (m_fault[u]) return;
        v = (m_bytes[u] >= 4);
        if (v && done[u] && chg[u]) begin
            if (npc[u][1:0] != 2'b00) begin
                m_fault[u] = 1'b1;
            end else begin
                m_pc[u]    = npc[u];
                m_addr[u]  = npc[u];
                m_bytes[u] = 0;
            end
            return;
        end
        if (m_bytes[u] < 8) m_bytes[u]++;
        if (v && done[u]) begin
            m_pc[u]    = m_pc[u] + 32'd4;
            m_bytes[u] = m_bytes[u] - 4;
        end
        if (m_bytes[u] < 8) m_addr[u] = m_pc[u] + 32'(m_bytes[u]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
    endtask

    // Leaves unit u at the start of cycle 0 (first cycle out of reset).
    task automatic restart(int u);
        rst_n[u] = 1'b0;
        done[u]  = 1'b0;
        chg[u]   = 1'b0;
        tick();
        rst_n[u] = 1'b1;
    endtask

    task automatic test_reset();
        rst_n[0] = 1'b0;
        rst_n[1] = 1'b0;
        tick();
        tick();
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (pc[u] !== rst_pc_of(u)) begin
                errors++;
                $display("FAIL reset_pc u%0d got %h want %h", u, pc[u], rst_pc_of(u));
            end
            checks++;
            if (imem_addr[u] !== rst_pc_of(u)) begin
                errors++;
                $display("FAIL reset_addr u%0d got %h want %h", u, imem_addr[u], rst_pc_of(u));
            end
            checks++;
            if (inst[u] !== NOP || valid[u] !== 1'b0 || fault[u] !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs u%0d got inst=%h valid=%b fault=%b want inst=%h valid=0 fault=0",
                         u, inst[u], valid[u], fault[u], NOP);
            end
        end
        $display("reset: pc0=%h pc1=%h", pc[0], pc[1]);
    endtask

    task automatic test_first_fetch();
        restart(0);
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (imem_addr[0] !== 32'(c)) begin
                errors++;
                $display("FAIL first_fetch_addr cycle %0d got %h want %h", c, imem_addr[0], 32'(c));
            end
            checks++;
            if (valid[0] !== (c >= 4)) begin
                errors++;
                $display("FAIL first_fetch_valid cycle %0d got %b want %b", c, valid[0], (c >= 4));
            end
            if (c == 4) begin
                checks++;
                if (inst[0] !== 32'h00A0_0513 || pc[0] !== 32'h0) begin
                    errors++;
                    $display("FAIL first_fetch_inst got inst=%h pc=%h want inst=00a00513 pc=00000000",
                             inst[0], pc[0]);
                end
                $display("first fetch: pc=%h inst=%h", pc[0], inst[0]);
            end
            tick();
        end
    endtask

    task automatic test_nop_done_ignored();
        restart(0);
        done[0] = 1'b1;
        for (int c = 0; c < 24; c++) begin
            if (c < 4) begin
                checks++;
                if (pc[0] !== 32'h0) begin
                    errors++;
                    $display("FAIL nop_done_pc cycle %0d got %h want 00000000", c, pc[0]);
                end
            end
            checks++;
            if (obs_vec(0) !== exp_vec(0)) begin
                errors++;
                $display("FAIL nop_done_vec cycle %0d got %h want %h", c, obs_vec(0), exp_vec(0));
            end
            if (valid[0] === 1'b1) $display("nop-done run: issue pc=%h inst=%h", pc[0], inst[0]);
            tick();
        end
        done[0] = 1'b0;
    endtask

    task automatic test_sequential();
        restart(0);
        for (int c = 0; c < 13; c++) begin
            done[0] = (c == 10);
            checks++;
            if (obs_vec(0) !== exp_vec(0)) begin
                errors++;
                $display("FAIL seq_vec cycle %0d got %h want %h", c, obs_vec(0), exp_vec(0));
            end
            if (c == 11) begin
                checks++;
                if (pc[0] !== 32'h4 || valid[0] !== 1'b1 || inst[0] !== word_at(32'h4)) begin
                    errors++;
                    $display("FAIL seq_zero_bubble got pc=%h valid=%b inst=%h want pc=00000004 valid=1 inst=%h",
                             pc[0], valid[0], inst[0], word_at(32'h4));
                end
                $display("sequential: pc=%h inst=%h", pc[0], inst[0]);
            end
            tick();
        end
        done[0] = 1'b0;
    endtask

    task automatic test_redirect();
        restart(0);
        npc[0] = 32'h0000_0100;
        for (int c = 0; c < 14; c++) begin
            done[0] = (c == 6);
            chg[0]  = (c == 6);
            checks++;
            if (obs_vec(0) !== exp_vec(0)) begin
                errors++;
                $display("FAIL redirect_vec cycle %0d got %h want %h", c, obs_vec(0), exp_vec(0));
            end
            if (c >= 7 && c <= 10) begin
                checks++;
                if (imem_addr[0] !== 32'h100 + 32'(c - 7) || valid[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL redirect_addr cycle %0d got addr=%h valid=%b want addr=%h valid=0",
                             c, imem_addr[0], valid[0], 32'h100 + 32'(c - 7));
                end
            end
            if (c == 11) begin
                checks++;
                if (valid[0] !== 1'b1 || pc[0] !== 32'h100 || inst[0] !== word_at(32'h100)) begin
                    errors++;
                    $display("FAIL redirect_issue got valid=%b pc=%h inst=%h want valid=1 pc=00000100 inst=%h",
                             valid[0], pc[0], inst[0], word_at(32'h100));
                end
                $display("redirect: pc=%h inst=%h", pc[0], inst[0]);
            end
            tick();
        end
        chg[0] = 1'b0;
        done[0] = 1'b0;
    endtask

    task automatic test_misaligned();
        restart(0);
        for (int c = 0; c < 16; c++) begin
            if (c == 5) begin
                done[0] = 1'b1;
                chg[0]  = 1'b1;
                npc[0]  = 32'h0000_0102;
            end else if (c > 5) begin
                done[0] = 1'($urandom_range(0, 1));
                chg[0]  = 1'($urandom_range(0, 1));
                npc[0]  = $urandom() & 32'h0000_03FC;
            end else begin
                done[0] = 1'b0;
                chg[0]  = 1'b0;
            end
            checks++;
            if (obs_vec(0) !== exp_vec(0)) begin
                errors++;
                $display("FAIL misalign_vec cycle %0d got %h want %h", c, obs_vec(0), exp_vec(0));
            end
            if (c >= 6) begin
                checks++;
                if (fault[0] !== 1'b1 || valid[0] !== 1'b0 || inst[0] !== NOP || pc[0] !== 32'h0) begin
                    errors++;
                    $display("FAIL misalign_fault cycle %0d got fault=%b valid=%b inst=%h pc=%h want 1 0 %h 00000000",
                             c, fault[0], valid[0], inst[0], pc[0], NOP);
                end
            end
            tick();
        end
        rst_n[0] = 1'b0;
        done[0]  = 1'b0;
        chg[0]   = 1'b0;
        tick();
        checks++;
        if (fault[0] !== 1'b0) begin
            errors++;
            $display("FAIL misalign_reset_clears got fault=%b want 0", fault[0]);
        end
        $display("misaligned: fault cleared by reset, fault=%b", fault[0]);
    endtask

    task automatic test_wrap();
        restart(1);
        for (int c = 0; c < 11; c++) begin
            done[1] = (c == 8);
            checks++;
            if (obs_vec(1) !== exp_vec(1)) begin
                errors++;
                $display("FAIL wrap_vec cycle %0d got %h want %h", c, obs_vec(1), exp_vec(1));
            end
            if (c >= 4 && c < 8) begin
                checks++;
                if (imem_addr[1] !== 32'(c - 4)) begin
                    errors++;
                    $display("FAIL wrap_prefetch_addr cycle %0d got %h want %h", c, imem_addr[1], 32'(c - 4));
                end
            end
            if (c == 9) begin
                checks++;
                if (pc[1] !== 32'h0 || valid[1] !== 1'b1 || inst[1] !== word_at(32'h0)) begin
                    errors++;
                    $display("FAIL wrap_pc got pc=%h valid=%b inst=%h want pc=00000000 valid=1 inst=%h",
                             pc[1], valid[1], inst[1], word_at(32'h0));
                end
                $display("wrap: pc=%h inst=%h", pc[1], inst[1]);
            end
            tick();
        end
        done[1]  = 1'b0;
        rst_n[1] = 1'b0;
    endtask

    task automatic test_random();
        int fault_cycles;
        fault_cycles = 0;
        restart(0);
        for (int c = 0; c < 3000; c++) begin
            fault_cycles = m_fault[0] ? fault_cycles + 1 : 0;
            rst_n[0] = !((fault_cycles > 6) || ($urandom_range(0, 499) == 0));
            done[0]  = ($urandom_range(0, 99) < 35);
            chg[0]   = done[0] && ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 15) == 0)
                npc[0] = ($urandom() & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
            else if ($urandom_range(0, 7) == 0)
                npc[0] = 32'hFFFF_FFF0 | (32'($urandom_range(0, 3)) << 2);
            else
                npc[0] = $urandom() & 32'h0000_03FC;
            checks++;
            if (obs_vec(0) !== exp_vec(0)) begin
                errors++;
                $display("FAIL random_vec cycle %0d got %h want %h", c, obs_vec(0), exp_vec(0));
            end
            if (rst_n[0] && done[0] && !m_fault[0] && m_bytes[0] >= 4)
                $display("txn pc=%h inst=%h redirect=%0d target=%h", m_pc[0], word_at(m_pc[0]), chg[0], npc[0]);
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom());
        mem[0] = 8'h13;
        mem[1] = 8'h05;
        mem[2] = 8'hA0;
        mem[3] = 8'h00;
        for (int u = 0; u < 2; u++) begin
            rst_n[u] = 1'b0;
            done[u]  = 1'b0;
            chg[u]   = 1'b0;
            npc[u]   = 32'h0;
        end
        @(negedge clk);
        test_reset();
        test_first_fetch();
        test_nop_done_ignored();
        test_sequential();
        test_redirect();
        test_misaligned();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
